// File: rtl/spi_pkg.sv
// Shared types and bit-order helpers for the SPI peripheral core.
// Optional feature macro: SPI_PERIPHERAL_LSB_FIRST_EN reverses both shift
// directions (LSB first). Undefined (default) is MSB first.
package spi_pkg;

  typedef logic [7:0] spi_byte_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

  localparam spi_byte_t SPI_FILL_BYTE = 8'h00;

  // Bit presented on POCI for a given TX shift register value
  function automatic logic tx_bit(input spi_byte_t b);
`ifdef SPI_PERIPHERAL_LSB_FIRST_EN
    return b[0];
`else
    return b[7];
`endif
  endfunction

  // Advance the TX shift register by one bit
  function automatic spi_byte_t tx_advance(input spi_byte_t b);
`ifdef SPI_PERIPHERAL_LSB_FIRST_EN
    return {1'b0, b[7:1]};
`else
    return {b[6:0], 1'b0};
`endif
  endfunction

  // Shift one received PICO bit into the RX shift register
  function automatic spi_byte_t rx_advance(input spi_byte_t s, input logic d);
`ifdef SPI_PERIPHERAL_LSB_FIRST_EN
    return {d, s[7:1]};
`else
    return {s[6:0], d};
`endif
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous SPI pin, plus rise/fall
// detection of the synchronized value against its previous-cycle value.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  // Synchronizer chain and one-cycle history; reset to the pin's idle level
  // so no spurious edge is seen coming out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= {SYNC_STAGES{RST_VAL}};
      prev  <= RST_VAL;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign sync = chain[SYNC_STAGES-1];
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/spi_peripheral_core.sv
// SPI mode-0 peripheral endpoint, oversampled on the local clock.
// Byte-wide TX holding buffer (valid/ready) and RX data-valid strobe.
// Optional feature macro: SPI_PERIPHERAL_LSB_FIRST_EN (LSB-first shifting).
module spi_peripheral_core
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  spi_byte_t tx_byte,
  input  logic      tx_dv,
  output logic      tx_ready,
  output logic      rx_dv,
  output spi_byte_t rx_byte,
  input  logic      spi_clk,
  input  logic      spi_cs_n,
  input  logic      spi_pico,
  output logic      spi_poci
);

  logic sclk_sync, sclk_rise, sclk_fall;
  logic cs_sync, cs_rise, cs_fall;
  logic pico_sync, pico_rise, pico_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .din(spi_clk),
    .sync(sclk_sync), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .din(spi_cs_n),
    .sync(cs_sync), .rise(cs_rise), .fall(cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_pico (
    .clk(clk), .rst(rst), .din(spi_pico),
    .sync(pico_sync), .rise(pico_rise), .fall(pico_fall)
  );

  // Only the synchronized PICO level and the sclk/cs edges are consumed
  logic unused_sync;
  assign unused_sync = ^{sclk_sync, cs_sync, pico_rise, pico_fall};

  spi_state_e state, state_nxt;
  logic [2:0] bit_cnt;
  spi_byte_t  rx_shift, tx_shift, hold_buf;
  logic       hold_full;

  logic load_slot;   // byte slot start: refill tx_shift from buffer or fill
  logic sample;      // sclk rise inside a frame
  logic shift_out;   // sclk fall mid-byte
  logic frame_end;   // cs_n rise inside a frame
  logic accept;      // tx_byte captured into the holding buffer
  spi_byte_t load_val, rx_nxt, tx_nxt;

  // Frame state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and per-cycle event decode; cs_n rise outranks sclk edges
  always_comb begin
    state_nxt = state;
    load_slot = 1'b0;
    sample    = 1'b0;
    shift_out = 1'b0;
    frame_end = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_nxt = ACTIVE;
          load_slot = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_nxt = IDLE;
          frame_end = 1'b1;
        end else begin
          sample    = sclk_rise;
          load_slot = sclk_fall && (bit_cnt == 3'd0);
          shift_out = sclk_fall && (bit_cnt != 3'd0);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A byte offered on the same cycle the buffer drains is still captured
  assign accept   = tx_dv && (!hold_full || load_slot);
  assign load_val = hold_full ? hold_buf : SPI_FILL_BYTE;
  assign rx_nxt   = rx_advance(rx_shift, pico_sync);
  assign tx_nxt   = tx_advance(tx_shift);
  assign tx_ready = ~hold_full;

  // TX holding buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_buf  <= SPI_FILL_BYTE;
      hold_full <= 1'b0;
    end else begin
      if (accept) hold_buf <= tx_byte;
      hold_full <= accept || (hold_full && !load_slot);
    end
  end

  // Receive shifter, bit counter and completed-byte strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_shift <= SPI_FILL_BYTE;
      rx_byte  <= SPI_FILL_BYTE;
      rx_dv    <= 1'b0;
      bit_cnt  <= 3'd0;
    end else begin
      rx_dv <= 1'b0;
      if (frame_end || (state == IDLE)) begin
        bit_cnt <= 3'd0;
      end else if (sample) begin
        rx_shift <= rx_nxt;
        bit_cnt  <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          rx_byte <= rx_nxt;
          rx_dv   <= 1'b1;
        end
      end
    end
  end

  // Transmit shifter and registered POCI; POCI is held low between frames
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_shift <= SPI_FILL_BYTE;
      spi_poci <= 1'b0;
    end else if (frame_end) begin
      spi_poci <= 1'b0;
    end else if (load_slot) begin
      tx_shift <= load_val;
      spi_poci <= tx_bit(load_val);
    end else if (shift_out) begin
      tx_shift <= tx_nxt;
      spi_poci <= tx_bit(tx_nxt);
    end
  end

endmodule

// File: tb/tb_spi_peripheral_core.sv
// Scoreboard bench for spi_peripheral_core: a bit-banged SPI controller
// drives frames, a byte-level model predicts POCI/RX bytes into queues, and a
// monitor compares them as the DUT produces rx_dv pulses and POCI bytes.
module tb_spi_peripheral_core;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_byte;
  logic       tx_dv;
  logic       tx_ready;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       spi_clk, spi_cs_n, spi_pico, spi_poci;

  int checks = 0;
  int errors = 0;

  spi_peripheral_core #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .tx_byte(tx_byte), .tx_dv(tx_dv),
    .tx_ready(tx_ready), .rx_dv(rx_dv), .rx_byte(rx_byte),
    .spi_clk(spi_clk), .spi_cs_n(spi_cs_n), .spi_pico(spi_pico),
    .spi_poci(spi_poci)
  );

  always #5 clk = ~clk;

  // Byte-level model: holding buffer, consumed at every byte slot start
  logic       m_full = 1'b0;
  logic [7:0] m_buf  = 8'h00;
  logic [7:0] m_rx_last = 8'h00;

  logic [7:0] exp_rx[$];
  logic [7:0] exp_poci[$];
  logic [7:0] obs_poci[$];

  // Frame description filled in before calling frame()
  logic [7:0] fr_pico[8];
  int         fr_wr[8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int bit_idx(input int k);
`ifdef SPI_PERIPHERAL_LSB_FIRST_EN
    return k;
`else
    return 7 - k;
`endif
  endfunction

  function automatic logic [7:0] model_load();
    logic [7:0] v;
    v = m_full ? m_buf : 8'h00;
    m_full = 1'b0;
    return v;
  endfunction

  task automatic send_tx(input logic [7:0] b);
    chk("tx_ready_before_write", int'(tx_ready), int'(!m_full));
    tx_byte = b;
    tx_dv   = 1'b1;
    if (!m_full) begin
      m_full = 1'b1;
      m_buf  = b;
    end
    tick(1);
    tx_dv = 1'b0;
  endtask

  // One chip-select frame: nbytes whole bytes, then tail_bits of a partial
  task automatic frame(input int nbytes, input int tail_bits);
    logic [7:0] cur, obs;
    int nb;
    spi_cs_n = 1'b0;
    cur = model_load();
    for (int b = 0; b <= nbytes; b++) begin
      nb = (b < nbytes) ? 8 : tail_bits;
      if (nb == 0) break;
      if (nb == 8) begin
        exp_rx.push_back(fr_pico[b]);
        exp_poci.push_back(cur);
        m_rx_last = fr_pico[b];
      end
      obs = 8'h00;
      for (int k = 0; k < nb; k++) begin
        spi_pico = fr_pico[b][bit_idx(k)];
        tick(4);
        if (k == 0 && b < nbytes && fr_wr[b] >= 0) send_tx(8'(fr_wr[b]));
        else tick(1);
        tick(1);
        obs[bit_idx(k)] = spi_poci;
        spi_clk = 1'b1;
        tick(6);
        spi_clk = 1'b0;
      end
      if (nb == 8) begin
        obs_poci.push_back(obs);
        cur = model_load();
      end
    end
    tick(4);
    spi_cs_n = 1'b1;
    tick(8);
    chk("idle_poci", int'(spi_poci), 0);
    chk("idle_tx_ready", int'(tx_ready), int'(!m_full));
  endtask

  task automatic clear_frame();
    for (int i = 0; i < 8; i++) begin
      fr_pico[i] = 8'h00;
      fr_wr[i]   = -1;
    end
  endtask

  // Monitor: pop expectations whenever the DUT presents a result
  initial begin
    logic [7:0] e, o;
    forever begin
      @(negedge clk);
      if (!rst && rx_dv) begin
        if (exp_rx.size() == 0) begin
          chk("rx_dv_unexpected", 1, 0);
        end else begin
          e = exp_rx.pop_front();
          chk("rx_byte", int'(rx_byte), int'(e));
        end
      end
      while (obs_poci.size() > 0 && exp_poci.size() > 0) begin
        o = obs_poci.pop_front();
        e = exp_poci.pop_front();
        chk("poci_byte", int'(o), int'(e));
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1; tx_byte = 8'h00; tx_dv = 1'b0;
    spi_clk = 1'b0; spi_cs_n = 1'b1; spi_pico = 1'b0;
    tick(4);
    rst = 1'b0;
    tick(4);
    chk("reset_tx_ready", int'(tx_ready), 1);
    chk("reset_rx_dv", int'(rx_dv), 0);
    chk("reset_poci", int'(spi_poci), 0);
    chk("reset_rx_byte", int'(rx_byte), 0);

    // Single byte with preload
    send_tx(8'hA5);
    chk("tx_ready_after_load", int'(tx_ready), 0);
    clear_frame(); fr_pico[0] = 8'h3C;
    frame(1, 0);

    // Three bytes, next TX byte written just after each slot start
    send_tx(8'h11);
    clear_frame();
    fr_pico[0] = 8'hDE; fr_pico[1] = 8'hAD; fr_pico[2] = 8'hBE;
    fr_wr[0] = 8'h22; fr_wr[1] = 8'h33;
    frame(3, 0);

    // No TX load: fill byte goes out
    clear_frame(); fr_pico[0] = 8'hFF;
    frame(1, 0);

    // Aborted after 5 bits, then a full frame
    clear_frame(); fr_pico[0] = 8'h6B;
    frame(0, 5);
    chk("rx_byte_after_abort", int'(rx_byte), int'(m_rx_last));
    clear_frame(); fr_pico[0] = 8'h81;
    frame(1, 0);

    // Second write while full is ignored
    send_tx(8'h55);
    send_tx(8'h66);
    clear_frame(); fr_pico[0] = 8'h42;
    frame(1, 0);

    // Randomized frames
    for (int r = 0; r < 8; r++) begin
      clear_frame();
      if ($urandom_range(0, 1) == 1) send_tx(8'($urandom));
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) begin
        fr_pico[i] = 8'($urandom);
        if ($urandom_range(0, 1) == 1) fr_wr[i] = int'($urandom_range(0, 255));
      end
      fr_pico[n] = 8'($urandom);
      frame(n, (r == 3) ? 3 : 0);
    end

    tick(20);
    chk("rx_pending", exp_rx.size(), 0);
    chk("poci_pending", exp_poci.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
